// File: rtl/pipe_stage_buf.sv
// Elastic pipeline buffer for decoded instruction fields: DEPTH register slots with
// valid/ready handshake, bubble collapsing, synchronous flush and an occupancy count.
module pipe_stage_buf #(
  parameter int unsigned OPCODE_W  = 4,
  parameter int unsigned OPERAND_W = 3,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DEST_W    = 3,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [OPERAND_W-1:0] operanda,
  input  logic [OPERAND_W-1:0] operandb,
  input  logic [ADDR_W-1:0]    dmaddr,
  input  logic [DEST_W-1:0]    dest,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPCODE_W-1:0]  out_opcode,
  output logic [OPERAND_W-1:0] out_operanda,
  output logic [OPERAND_W-1:0] out_operandb,
  output logic [ADDR_W-1:0]    out_dmaddr,
  output logic [DEST_W-1:0]    out_dest,
  output logic [CNT_W-1:0]     count
);

  localparam int unsigned PayloadW = OPCODE_W + 2 * OPERAND_W + ADDR_W + DEST_W;

  typedef logic [PayloadW-1:0] payload_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] move;
  payload_t         data_q [DEPTH];
  payload_t         data_d [DEPTH];
  payload_t         in_data, out_data;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept, xfer;

  assign in_data = {opcode, operanda, operandb, dmaddr, dest};

  // Walk from the output side: a slot may advance when the slot ahead is empty or leaving.
  always_comb begin
    logic go, mv;
    move = '0;
    go   = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      mv      = valid_q[k] & go & ~flush;
      move[k] = mv;
      go      = ~valid_q[k] | mv;
    end
  end

  assign in_ready = (~valid_q[0] | move[0]) & ~flush & ~rst;
  assign accept   = in_valid & in_ready;
  assign xfer     = move[DEPTH-1];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 1; k < int'(DEPTH); k++) begin
      if (move[k-1]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = data_q[k-1];
      end else if (move[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    if (accept) begin
      valid_d[0] = 1'b1;
      data_d[0]  = in_data;
    end else if (move[0]) begin
      valid_d[0] = 1'b0;
    end
    if (flush) begin
      valid_d = '0;
      for (int k = 0; k < int'(DEPTH); k++) data_d[k] = '0;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({accept, xfer})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int k = 0; k < int'(DEPTH); k++) data_q[k] <= data_d[k];
    end
  end

  // An empty output presents all-zero fields, i.e. a NOP.
  assign out_valid = valid_q[DEPTH-1] & ~flush;
  assign out_data  = out_valid ? data_q[DEPTH-1] : '0;
  assign {out_opcode, out_operanda, out_operandb, out_dmaddr, out_dest} = out_data;
  assign count = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH=2 and DEPTH=3 instances share stimulus and are checked
// against a slot-occupancy model that shifts entries forward one position at a time.
module tb_pipe_stage_buf;

  localparam int PW = 17;
  localparam int OW = 21;

  logic clk, rst;
  logic in_valid, flush, out_ready;
  logic [3:0] opcode, dmaddr;
  logic [2:0] operanda, operandb, dest;

  logic [1:0]      rdy, ov;
  logic [1:0][3:0] oop, odm;
  logic [1:0][2:0] oa, ob, ods;
  logic [1:0][1:0] cnt;

  int vectors = 0;
  int miscompares = 0;

  bit            mv [2][3];
  bit            nv [2][3];
  logic [PW-1:0] mp [2][3];
  logic [PW-1:0] np [2][3];
  logic [OW-1:0] exp_obs [2];

  pipe_stage_buf #(.DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .opcode(opcode),
    .operanda(operanda), .operandb(operandb), .dmaddr(dmaddr), .dest(dest), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_opcode(oop[0]), .out_operanda(oa[0]),
    .out_operandb(ob[0]), .out_dmaddr(odm[0]), .out_dest(ods[0]), .count(cnt[0])
  );

  pipe_stage_buf #(.DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .opcode(opcode),
    .operanda(operanda), .operandb(operandb), .dmaddr(dmaddr), .dest(dest), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_opcode(oop[1]), .out_operanda(oa[1]),
    .out_operandb(ob[1]), .out_dmaddr(odm[1]), .out_dest(ods[1]), .count(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1);
  end

  function automatic logic [OW-1:0] obs(input int d);
    return {rdy[d], ov[d], oop[d], oa[d], ob[d], odm[d], ods[d], cnt[d]};
  endfunction

  // Model: entries hop forward one slot per cycle if the slot ahead ends up empty.
  task automatic model_eval();
    for (int d = 0; d < 2; d++) begin
      int  dd = (d == 0) ? 2 : 3;
      int  c  = 0;
      bit  er, ev;
      for (int k = 0; k < 3; k++) begin
        nv[d][k] = 1'b0;
        np[d][k] = mp[d][k];
      end
      for (int k = dd - 1; k >= 0; k--) begin
        if (mv[d][k]) begin
          c++;
          if (k == dd - 1) begin
            if (!out_ready) nv[d][k] = 1'b1;
          end else if (!nv[d][k+1]) begin
            nv[d][k+1] = 1'b1;
            np[d][k+1] = mp[d][k];
          end else begin
            nv[d][k] = 1'b1;
          end
        end
      end
      er = !nv[d][0] && !flush && !rst;
      ev = mv[d][dd-1] && !flush;
      exp_obs[d] = {er, ev, (ev ? mp[d][dd-1] : {PW{1'b0}}), c[1:0]};
      if (er && in_valid) begin
        nv[d][0] = 1'b1;
        np[d][0] = {opcode, operanda, operandb, dmaddr, dest};
      end
      if (flush || rst) for (int k = 0; k < 3; k++) nv[d][k] = 1'b0;
    end
  endtask

  task automatic model_commit();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) begin
        mv[d][k] = nv[d][k];
        mp[d][k] = np[d][k];
      end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) mv[d][k] = 1'b0;
  endtask

  task automatic drive(input bit iv, input logic [3:0] op, input bit fl, input bit ordy);
    in_valid  = iv;
    opcode    = op;
    operanda  = 3'($urandom);
    operandb  = 3'($urandom);
    dmaddr    = 4'($urandom);
    dest      = op[2:0];
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      settle();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== {OW{1'b0}}) begin
          miscompares++;
          $display("FAIL reset_outputs dut%0d: observed %h required %h", d, obs(d), {OW{1'b0}});
        end
      end
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    settle();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (rdy[d] !== 1'b1 || obs(d) !== exp_obs[d]) begin
        miscompares++;
        $display("FAIL reset_release dut%0d: observed %h required %h", d, obs(d), exp_obs[d]);
      end
    end
    tick();
  endtask

  task automatic test_streaming();
    logic [3:0] seen[$];
    for (int i = 0; i < 10; i++) begin
      drive(i < 5, 4'(i + 1), 1'b0, 1'b1);
      settle();
      if (ov[0] && out_ready) seen.push_back(oop[0]);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== exp_obs[d]) begin
          miscompares++;
          $display("FAIL stream dut%0d cyc%0d: observed %h required %h", d, i, obs(d), exp_obs[d]);
        end
      end
      if (i >= 2 && i <= 4) begin
        vectors++;
        if (cnt[0] !== 2'd2) begin
          miscompares++;
          $display("FAIL stream_count cyc%0d: observed %0d required 2", i, cnt[0]);
        end
      end
      tick();
    end
    vectors++;
    if (seen.size() != 5 || seen[0] !== 4'd1 || seen[1] !== 4'd2 || seen[2] !== 4'd3 ||
        seen[3] !== 4'd4 || seen[4] !== 4'd5) begin
      miscompares++;
      $display("FAIL stream_order: observed %p required 1..5", seen);
    end
  endtask

  task automatic test_stall();
    logic [3:0] seen[$];
    bit         took9 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      drive(1'b1, 4'd7, 1'b0, 1'b0);
      else if (i == 1) drive(1'b1, 4'd8, 1'b0, 1'b0);
      else             drive(!took9, 4'd9, 1'b0, i >= 6);
      settle();
      if (ov[0] && out_ready) seen.push_back(oop[0]);
      if (i >= 6 && in_valid && rdy[0]) took9 = 1'b1;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== exp_obs[d]) begin
          miscompares++;
          $display("FAIL stall dut%0d cyc%0d: observed %h required %h", d, i, obs(d), exp_obs[d]);
        end
      end
      if (i >= 2 && i < 6) begin
        vectors++;
        if (rdy[0] !== 1'b0 || oop[0] !== 4'd7 || cnt[0] !== 2'd2) begin
          miscompares++;
          $display("FAIL stall_hold cyc%0d: observed rdy=%b op=%0d cnt=%0d required 0/7/2",
                   i, rdy[0], oop[0], cnt[0]);
        end
      end
      tick();
    end
    vectors++;
    if (seen.size() != 3 || seen[0] !== 4'd7 || seen[1] !== 4'd8 || seen[2] !== 4'd9) begin
      miscompares++;
      $display("FAIL stall_order: observed %p required 7,8,9", seen);
    end
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      drive(1'b1, 4'd3, 1'b0, 1'b0);
      else if (i == 1) drive(1'b0, 4'd0, 1'b0, 1'b0);
      else if (i == 2) drive(1'b1, 4'd4, 1'b0, 1'b0);
      else             drive(1'b1, 4'($urandom), 1'b0, 1'b0);
      settle();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== exp_obs[d]) begin
          miscompares++;
          $display("FAIL bubble dut%0d cyc%0d: observed %h required %h", d, i, obs(d), exp_obs[d]);
        end
      end
      if (i == 3) begin
        vectors++;
        if (cnt[1] !== 2'd2) begin
          miscompares++;
          $display("FAIL bubble_count: observed %0d required 2", cnt[1]);
        end
      end
      if (cnt[1] < 2'd3) begin
        vectors++;
        if (rdy[1] !== 1'b1) begin
          miscompares++;
          $display("FAIL bubble_ready cyc%0d: observed %b required 1", i, rdy[1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      if (i == 0)      drive(1'b1, 4'd5, 1'b0, 1'b0);
      else if (i == 1) drive(1'b1, 4'd6, 1'b0, 1'b0);
      else if (i == 2) drive(1'b1, 4'd9, 1'b1, 1'($urandom));
      else             drive(1'b0, 4'd0, 1'b0, 1'b0);
      settle();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== exp_obs[d]) begin
          miscompares++;
          $display("FAIL flush dut%0d cyc%0d: observed %h required %h", d, i, obs(d), exp_obs[d]);
        end
        if (i == 2) begin
          vectors++;
          if (ov[d] !== 1'b0 || rdy[d] !== 1'b0 || cnt[d] !== 2'd2) begin
            miscompares++;
            $display("FAIL flush_cycle dut%0d: observed ov=%b rdy=%b cnt=%0d required 0/0/2",
                     d, ov[d], rdy[d], cnt[d]);
          end
        end
        if (i == 3) begin
          vectors++;
          if (obs(d) !== {1'b1, {(OW-1){1'b0}}}) begin
            miscompares++;
            $display("FAIL flush_after dut%0d: observed %h required %h", d, obs(d),
                     {1'b1, {(OW-1){1'b0}}});
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 4'($urandom), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 2) != 0));
      settle();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== exp_obs[d]) begin
          miscompares++;
          $display("FAIL random dut%0d cyc%0d: observed %h required %h", d, i, obs(d), exp_obs[d]);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    settle();
    tick();
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    settle();
    tick();
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    settle();
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    settle();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (cnt[d] !== 2'd2) begin
        miscompares++;
        $display("FAIL areset_pre dut%0d: observed cnt=%0d required 2", d, cnt[d]);
      end
    end
    #1 rst = 1'b1;
    model_clear();
    settle();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (ov[d] !== 1'b0 || cnt[d] !== 2'd0 || obs(d) !== exp_obs[d]) begin
        miscompares++;
        $display("FAIL areset_mid dut%0d: observed %h required %h", d, obs(d), exp_obs[d]);
      end
    end
    tick();
    rst = 1'b0;
    drive(1'b1, 4'd11, 1'b0, 1'b1);
    settle();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (rdy[d] !== 1'b1 || obs(d) !== exp_obs[d]) begin
        miscompares++;
        $display("FAIL areset_release dut%0d: observed %h required %h", d, obs(d), exp_obs[d]);
      end
    end
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    settle();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (cnt[d] !== 2'd1 || obs(d) !== exp_obs[d]) begin
        miscompares++;
        $display("FAIL areset_first dut%0d: observed %h required %h", d, obs(d), exp_obs[d]);
      end
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    model_clear();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_streaming();
    test_stall();
    drive(1'b0, 4'd0, 1'b1, 1'b1);
    settle();
    tick();
    test_bubble();
    drive(1'b0, 4'd0, 1'b1, 1'b1);
    settle();
    tick();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic pipeline buffer carrying decoded instruction fields (opcode, operanda, operandb, dmaddr, dest) between pipeline stages, e.g. IF->ID.
- Generalises the fixed two-stage delay line. Adds configurable field widths, configurable depth, valid/ready handshaking with backpressure (stall), bubble collapsing, synchronous flush and an occupancy count.

Parameters:
- OPCODE_W, 4, opcode field width
- OPERAND_W, 3, width of operanda and operandb
- ADDR_W, 4, dmaddr width
- DEST_W, 3, dest width
- DEPTH, 2, number of register slots (>=1); unstalled latency in cycles
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream presents a valid instruction
- in_ready  out  1  buffer accepts this cycle (combinational)
- opcode  in  OPCODE_W  incoming opcode
- operanda  in  OPERAND_W  incoming operand a
- operandb  in  OPERAND_W  incoming operand b
- dmaddr  in  ADDR_W  incoming data-memory address
- dest  in  DEST_W  incoming destination register
- flush  in  1  synchronous kill of all buffered instructions
- out_valid  out  1  output slot holds a valid instruction
- out_ready  in  1  downstream consumes; low = stall
- out_opcode / out_operanda / out_operandb / out_dmaddr / out_dest  out  field widths  fields of output slot
- count  out  CNT_W  number of valid slots

Behaviour:
- Storage: slots 0..DEPTH-1. Slot 0 is the input side; slot DEPTH-1 drives the out_* fields. Each slot has a valid bit plus a payload.
- Reset (async, rst=1): all valid bits 0, all payloads 0, count=0, out_valid=0, out_* = 0. in_ready = 0 while rst is high.
- Move chain (combinational):
  - move[DEPTH-1] = valid[DEPTH-1] & out_ready & ~flush
  - move[k] = valid[k] & (~valid[k+1] | move[k+1]) & ~flush
- in_ready = (~valid[0] | move[0]) & ~flush & ~rst.
- Accept: in_valid & in_ready. At the clock edge, slot 0 loads the input fields and sets valid.
- Advance: on move[k], slot k+1 loads slot k's payload and valid. A slot that moves out and is not refilled clears valid and keeps its stale payload internally.
- Bubbles collapse: an invalid slot is filled by the slot behind it even when the output is stalled.
- out_valid = valid[DEPTH-1] & ~flush. out_* show the slot DEPTH-1 payload when valid and are forced to 0 when out_valid=0, so an invalid output is a NOP (opcode 0).
- Latency: with out_ready held 1, an instruction accepted at edge N appears on out_* with out_valid=1 after edge N+DEPTH-1 and is consumed at edge N+DEPTH. Throughput is 1 per cycle.
- Stall: while out_ready=0 and all slots are valid, in_ready=0 and all payloads hold unchanged. No loss and no duplication.
- Flush (priority over everything but rst):
  - At the edge, all valid bits and payloads are cleared and count goes to 0.
  - During the flush cycle, in_ready=0 and out_valid=0, so there is no accept and no transfer.
- count: registered. It increments on accept without output transfer, decrements on transfer without accept, and is unchanged when both or neither occur. Range 0..DEPTH, never wraps.
- Simultaneous accept and output transfer with a full buffer is allowed: in_ready=1 when out_ready=1.
- rst asserted mid-stream clears immediately, regardless of clk. The first accept after deassertion is at the first edge with in_valid=1.
- DEPTH=1: single slot; in_ready = ~valid[0] | out_ready.

Test Plan:
- Reset: hold rst=1 with random inputs -> out_valid=0, all out_* =0, count=0, in_ready=0. Deassert -> in_ready=1.
- Streaming (DEPTH=2, out_ready=1): send opcode 1..5 back-to-back with dest=opcode -> out_opcode sequence 1..5, each 2 cycles after accept, one per cycle, count steady at 2.
- Stall: fill with opcode 7,8, hold out_ready=0 for 4 cycles while in_valid=1 with opcode 9 -> in_ready=0, out_opcode=7 held, count=2. Release -> outputs 7,8,9 in order, no duplicate.
- Bubble collapse (DEPTH=3): accept opcode 3, idle 1 cycle, accept opcode 4, out_ready=0 -> count=2, then slots compact so in_ready stays 1 until count=3.
- Flush: buffer holding opcodes 5,6 (count=2), pulse flush with in_valid=1 opcode 9 -> out_valid=0 that cycle, opcode 9 not accepted, next cycle count=0, out_* =0.
- Async reset mid-stream: assert rst between edges with count=2 -> out_valid drops to 0 before the next clk edge, count=0.
